// File: rtl/fifo_hs_pkg.sv
// Shared helpers for hs_width_fifo: width/ratio derivation, pointer and occupancy widths,
// and the saturating counter increment.
package fifo_hs_pkg;

  typedef logic [63:0] cnt_wide_t;

  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < val) begin
      pow = pow << 1;
      res++;
    end
    return res;
  endfunction

  function automatic int unsigned min_w(input int unsigned in_w, input int unsigned out_w);
    return (in_w < out_w) ? in_w : out_w;
  endfunction

  function automatic int unsigned max_w(input int unsigned in_w, input int unsigned out_w);
    return (in_w > out_w) ? in_w : out_w;
  endfunction

  function automatic int unsigned in_ratio(input int unsigned in_w, input int unsigned out_w);
    return in_w / min_w(in_w, out_w);
  endfunction

  function automatic int unsigned out_ratio(input int unsigned in_w, input int unsigned out_w);
    return out_w / min_w(in_w, out_w);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return clog2(depth);
  endfunction

  // One extra bit so a completely full FIFO (occupancy == depth) is representable.
  function automatic int unsigned occ_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic cnt_wide_t sat_inc(input cnt_wide_t val, input int unsigned width);
    cnt_wide_t max_val;
    max_val = (width >= 64) ? '1 : ((cnt_wide_t'(1) << width) - cnt_wide_t'(1));
    return (val >= max_val) ? max_val : val + cnt_wide_t'(1);
  endfunction

endpackage

// File: rtl/hs_width_fifo_mem.sv
// Register-array storage for hs_width_fifo: multi-word write slice at wr_ptr, multi-word
// combinational read slice at rd_ptr, both addressed modulo Depth.
module hs_width_fifo_mem #(
  parameter int unsigned Depth   = 128,
  parameter int unsigned MinW    = 32,
  parameter int unsigned WrWords = 4,
  parameter int unsigned RdWords = 1,
  parameter int unsigned PtrW    = 7
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [PtrW-1:0]         wr_ptr_i,
  input  logic [WrWords*MinW-1:0] wdata_i,
  input  logic [PtrW-1:0]         rd_ptr_i,
  output logic [RdWords*MinW-1:0] rdata_o
);

  logic [MinW-1:0] mem_q [Depth];

  // Address arithmetic truncates to PtrW bits, so a slice straddling the end wraps to 0.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < WrWords; i++) begin
        mem_q[wr_ptr_i + PtrW'(i)] <= wdata_i[i*MinW +: MinW];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < RdWords; i++) begin
      rdata_o[i*MinW +: MinW] = mem_q[rd_ptr_i + PtrW'(i)];
    end
  end

endmodule

// File: rtl/hs_width_fifo.sv
// Single-clock ready/valid FIFO with integer-ratio width conversion, synchronous flush,
// occupancy output and saturating full/empty stall counters.
module hs_width_fifo
  import fifo_hs_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [IN_WIDTH-1:0]   d_a,
  input  logic                  vld_a,
  output logic                  rdy_a,
  output logic [OUT_WIDTH-1:0]  d_b,
  output logic                  vld_b,
  input  logic                  rdy_b,
  input  logic                  is_done_mode_user,
  output logic [clog2(DEPTH):0] occupancy,
  output logic [CNT_WIDTH-1:0]  full_cnt,
  output logic [CNT_WIDTH-1:0]  empty_cnt
);

  localparam int unsigned MinW     = min_w(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned InRatio  = in_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned OutRatio = out_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned PtrW     = ptr_w(DEPTH);
  localparam int unsigned OccW     = occ_w(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [OccW-1:0] occ_t;

  if ((IN_WIDTH % OUT_WIDTH) != 0 && (OUT_WIDTH % IN_WIDTH) != 0) begin : gen_bad_ratio
    $error("hs_width_fifo: IN_WIDTH and OUT_WIDTH must divide one another");
  end
  if ((DEPTH & (DEPTH - 1)) != 0 ||
      DEPTH < 2 * max_w(IN_WIDTH, OUT_WIDTH) / MinW) begin : gen_bad_depth
    $error("hs_width_fifo: DEPTH must be a power of 2 and hold two max-width words");
  end
  if (CNT_WIDTH == 0 || CNT_WIDTH > 64) begin : gen_bad_cnt
    $error("hs_width_fifo: CNT_WIDTH must be in 1..64");
  end

  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  occ_t                 occ_q, occ_d;
  logic [CNT_WIDTH-1:0] full_cnt_q, full_cnt_d;
  logic [CNT_WIDTH-1:0] empty_cnt_q, empty_cnt_d;
  logic                 push, pop;

  // Handshake depends on registered occupancy only; a pop in the same cycle does not free room.
  assign rdy_a = ((occ_t'(DEPTH) - occ_q) >= occ_t'(InRatio)) && !clear;
  assign vld_b = occ_q >= occ_t'(OutRatio);
  assign push  = vld_a && rdy_a;
  assign pop   = vld_b && rdy_b;

  assign occupancy = occ_q;
  assign full_cnt  = full_cnt_q;
  assign empty_cnt = empty_cnt_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    full_cnt_d  = full_cnt_q;
    empty_cnt_d = empty_cnt_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(InRatio);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(OutRatio);
      end
      occ_d = occ_q + (push ? occ_t'(InRatio) : '0) - (pop ? occ_t'(OutRatio) : '0);
    end

    if (!rdy_a && !is_done_mode_user) begin
      full_cnt_d = CNT_WIDTH'(sat_inc(cnt_wide_t'(full_cnt_q), CNT_WIDTH));
    end
    if (!vld_b && !is_done_mode_user) begin
      empty_cnt_d = CNT_WIDTH'(sat_inc(cnt_wide_t'(empty_cnt_q), CNT_WIDTH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      full_cnt_q  <= '0;
      empty_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      full_cnt_q  <= full_cnt_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  hs_width_fifo_mem #(
    .Depth  (DEPTH),
    .MinW   (MinW),
    .WrWords(InRatio),
    .RdWords(OutRatio),
    .PtrW   (PtrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .wr_ptr_i(wr_ptr_q),
    .wdata_i (d_a),
    .rd_ptr_i(rd_ptr_q),
    .rdata_o (d_b)
  );

endmodule

// File: tb/tb_hs_width_fifo.sv
// Bench for hs_width_fifo: a downsizer (128->32) and an upsizer (32->128) checked every cycle
// against a word-queue reference model, plus directed boundary scenarios.
module tb_hs_width_fifo;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   clr = '0, vld_a = '0, rdy_b = '0, done = '0;
  logic [1:0]   rdy_a, vld_b;
  logic [127:0] dn_d_a = '0, up_d_b;
  logic [31:0]  dn_d_b, up_d_a = '0;
  logic [7:0]   occ0, occ1;
  logic [31:0]  fcnt0, fcnt1, ecnt0, ecnt1;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of 32-bit words per instance plus expected stall counters.
  logic [31:0] wq0[$];
  logic [31:0] wq1[$];
  logic [31:0] fmod [2];
  logic [31:0] emod [2];

  always #5 clk = ~clk;

  hs_width_fifo #(.IN_WIDTH(128), .OUT_WIDTH(32), .DEPTH(128), .CNT_WIDTH(32)) u_dn (
    .clk(clk), .reset_n(reset_n), .clear(clr[0]), .d_a(dn_d_a), .vld_a(vld_a[0]),
    .rdy_a(rdy_a[0]), .d_b(dn_d_b), .vld_b(vld_b[0]), .rdy_b(rdy_b[0]),
    .is_done_mode_user(done[0]), .occupancy(occ0), .full_cnt(fcnt0), .empty_cnt(ecnt0)
  );

  hs_width_fifo #(.IN_WIDTH(32), .OUT_WIDTH(128), .DEPTH(128), .CNT_WIDTH(32)) u_up (
    .clk(clk), .reset_n(reset_n), .clear(clr[1]), .d_a(up_d_a), .vld_a(vld_a[1]),
    .rdy_a(rdy_a[1]), .d_b(up_d_b), .vld_b(vld_b[1]), .rdy_b(rdy_b[1]),
    .is_done_mode_user(done[1]), .occupancy(occ1), .full_cnt(fcnt1), .empty_cnt(ecnt1)
  );

  task automatic check(input int k, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  function automatic int unsigned qsize(input int k);
    return (k == 0) ? wq0.size() : wq1.size();
  endfunction

  function automatic logic [31:0] qpeek(input int k, input int unsigned i);
    return (k == 0) ? wq0[i] : wq1[i];
  endfunction

  task automatic qpush(input int k, input logic [31:0] w);
    if (k == 0) wq0.push_back(w);
    else        wq1.push_back(w);
  endtask

  task automatic qdrop(input int k, input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      if (k == 0) void'(wq0.pop_front());
      else        void'(wq1.pop_front());
    end
  endtask

  task automatic qclear(input int k);
    if (k == 0) wq0.delete();
    else        wq1.delete();
  endtask

  // Compares the DUT against the model state, then advances the model by the coming edge.
  task automatic model_step(input int k);
    int unsigned  ir, orr, occ;
    logic         exp_rdy, exp_vld;
    logic [127:0] dav, dbv, exp_db;
    ir      = (k == 0) ? 4 : 1;
    orr     = (k == 0) ? 1 : 4;
    occ     = qsize(k);
    exp_rdy = ((128 - occ) >= ir) && !clr[k];
    exp_vld = occ >= orr;
    dav     = (k == 0) ? dn_d_a : {96'b0, up_d_a};
    dbv     = (k == 0) ? {96'b0, dn_d_b} : up_d_b;
    check(k, "occupancy", (k == 0) ? occ0 : occ1, occ);
    check(k, "rdy_a", rdy_a[k], exp_rdy);
    check(k, "vld_b", vld_b[k], exp_vld);
    check(k, "full_cnt", (k == 0) ? fcnt0 : fcnt1, fmod[k]);
    check(k, "empty_cnt", (k == 0) ? ecnt0 : ecnt1, emod[k]);
    if (exp_vld) begin
      exp_db = '0;
      for (int i = 0; i < int'(orr); i++) exp_db[i*32 +: 32] = qpeek(k, i);
      check(k, "d_b", dbv, exp_db);
    end
    if (!exp_rdy && !done[k] && fmod[k] != 32'hFFFF_FFFF) fmod[k] = fmod[k] + 1;
    if (!exp_vld && !done[k] && emod[k] != 32'hFFFF_FFFF) emod[k] = emod[k] + 1;
    if (clr[k]) begin
      qclear(k);
    end else begin
      if (exp_vld && rdy_b[k]) qdrop(k, orr);
      if (vld_a[k] && exp_rdy) begin
        for (int i = 0; i < int'(ir); i++) qpush(k, dav[i*32 +: 32]);
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic model_reset();
    wq0.delete();
    wq1.delete();
    fmod[0] = '0; fmod[1] = '0;
    emod[0] = '0; emod[1] = '0;
  endtask

  // Called at negedge+2: asserts reset off-edge and checks outputs respond immediately.
  task automatic reset_pulse();
    #1 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check(k, "rst_rdy_a", rdy_a[k], 1'b1);
      check(k, "rst_vld_b", vld_b[k], 1'b0);
      check(k, "rst_empty_cnt", (k == 0) ? ecnt0 : ecnt1, 0);
      check(k, "rst_occ", (k == 0) ? occ0 : occ1, 0);
    end
    model_reset();
    vld_a = '0;
    rdy_b = '0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int cycles;
    bit did_rst;
    logic [31:0] fc, ec;

    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    check(0, "init_rdy_a", rdy_a[0], 1'b1);
    check(1, "init_vld_b", vld_b[1], 1'b0);

    // Downsize: one 128-bit push leaves as four LSB-first words.
    @(negedge clk);
    vld_a[0] = 1'b1;
    dn_d_a   = 128'h00000004_00000003_00000002_00000001;
    @(negedge clk);
    vld_a[0] = 1'b0;
    rdy_b[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check(0, "dn_occ_seq", occ0, 4 - i);
      check(0, "dn_data_seq", dn_d_b, i + 1);
      @(negedge clk);
    end
    rdy_b[0] = 1'b0;
    #2;
    check(0, "dn_occ_empty", occ0, 0);
    check(0, "dn_vld_empty", vld_b[0], 1'b0);

    // Upsize: vld_b stays low until four words are stored.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      vld_a[1] = 1'b1;
      up_d_a   = i;
      #2;
      check(1, "up_partial_vld", vld_b[1], 1'b0);
    end
    @(negedge clk);
    vld_a[1] = 1'b0;
    rdy_b[1] = 1'b1;
    #2;
    check(1, "up_vld", vld_b[1], 1'b1);
    check(1, "up_data", up_d_b, 128'h00000004_00000003_00000002_00000001);
    @(negedge clk);
    rdy_b[1] = 1'b0;
    #2;
    check(1, "up_occ_empty", occ1, 0);

    // Fill downsizer with rdy_b low; extra writes while full are ignored.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      vld_a[0] = 1'b1;
      dn_d_a   = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    #2;
    check(0, "fill_occ", occ0, 128);
    check(0, "fill_rdy_a", rdy_a[0], 1'b0);
    fc = fcnt0;
    repeat (5) @(negedge clk);
    #2;
    check(0, "full_cnt_rise", fcnt0, fc + 5);
    @(negedge clk);
    done[0] = 1'b1;
    #2;
    fc = fcnt0;
    repeat (5) @(negedge clk);
    #2;
    check(0, "full_cnt_frozen", fcnt0, fc);

    // Drain to 124, then push and pop together.
    @(negedge clk);
    done[0]  = 1'b0;
    vld_a[0] = 1'b0;
    rdy_b[0] = 1'b1;
    repeat (4) @(negedge clk);
    vld_a[0] = 1'b1;
    dn_d_a   = {$urandom, $urandom, $urandom, $urandom};
    #2;
    check(0, "occ_124", occ0, 124);
    @(negedge clk);
    vld_a[0] = 1'b0;
    rdy_b[0] = 1'b0;
    #2;
    check(0, "pushpop_occ", occ0, 127);
    check(0, "pushpop_rdy_a", rdy_a[0], 1'b0);

    @(negedge clk);
    rdy_b[0] = 1'b1;
    repeat (127) @(negedge clk);
    rdy_b[0] = 1'b0;
    #2;
    check(0, "drained_occ", occ0, 0);

    // Clear at occupancy 40 with a push and pop pending; counters frozen for the check.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vld_a[0] = 1'b1;
      dn_d_a   = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    clr[0]   = 1'b1;
    rdy_b[0] = 1'b1;
    done[0]  = 1'b1;
    #2;
    check(0, "pre_clear_occ", occ0, 40);
    fc = fcnt0;
    ec = ecnt0;
    @(negedge clk);
    clr[0]   = 1'b0;
    vld_a[0] = 1'b0;
    rdy_b[0] = 1'b0;
    done[0]  = 1'b0;
    #2;
    check(0, "clear_occ", occ0, 0);
    check(0, "clear_vld_b", vld_b[0], 1'b0);
    check(0, "clear_full_cnt", fcnt0, fc);
    check(0, "clear_empty_cnt", ecnt0, ec);

    // Random streaming through both instances with a reset pulse mid-stream.
    n       = 0;
    cycles  = 0;
    did_rst = 1'b0;
    while (n < 2000 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      vld_a[1] = ($urandom_range(0, 3) != 0);
      up_d_a   = $urandom;
      rdy_b[1] = ($urandom_range(0, 2) != 0);
      vld_a[0] = ($urandom_range(0, 1) != 0);
      dn_d_a   = {$urandom, $urandom, $urandom, $urandom};
      rdy_b[0] = ($urandom_range(0, 3) != 0);
      #2;
      if (vld_a[1] && rdy_a[1]) n++;
      if (!did_rst && n >= 1000) begin
        did_rst = 1'b1;
        reset_pulse();
      end
    end
    check(1, "stream_words_done", n >= 2000, 1'b1);

    @(negedge clk);
    vld_a = '0;
    rdy_b = 2'b11;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (occ0 == 0 && occ1 < 4) break;
    end
    check(0, "final_drain_occ", occ0, 0);
    check(1, "final_drain_vld", vld_b[1], 1'b0);

    @(negedge clk);
    rdy_b = '0;
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
